// File: rtl/mem_lane_ctrl.sv
// Load/store sequencer between the core's request port and a word-wide,
// synchronous-read data memory: lane extraction, sign/zero extension and RMW.
module mem_lane_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned WA_W   = ADDR_W - 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;

  // Request fields latched at accept
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [HALF_W-1:0]   wdata_q, wdata_d;

  // Registered outputs
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [WA_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                req_err_c;
  logic [7:0]          lane_byte_c;
  logic [HALF_W-1:0]   lane_half_c;
  logic [DATA_W-1:0]   load_ext_c;
  logic [DATA_W-1:0]   merged_c;

  // Misaligned or illegal-size requests never touch memory
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = (req_addr[1:0] != 2'b00);
      SZ_ILL:  req_err_c = 1'b1;
      default: req_err_c = 1'b0;
    endcase
  end

  // Lane extraction and extension of the word captured from memory
  always_comb begin
    lane_byte_c = mem_rdata[{off_q, 3'b000} +: 8];
    lane_half_c = mem_rdata[{off_q[1], 4'b0000} +: HALF_W];
    case (size_q)
      SZ_BYTE: load_ext_c = {{24{lane_byte_c[7] & ~uns_q}}, lane_byte_c};
      SZ_HALF: load_ext_c = {{16{lane_half_c[15] & ~uns_q}}, lane_half_c};
      default: load_ext_c = mem_rdata;
    endcase
  end

  // Read-modify-write merge: old word with the addressed lane(s) replaced
  always_comb begin
    merged_c = mem_rdata;
    if (size_q == SZ_BYTE) begin
      merged_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_c[{off_q[1], 4'b0000} +: HALF_W] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_wdata_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          uns_d      = req_unsigned;
          off_d      = req_addr[1:0];
          wdata_d    = req_wdata[HALF_W-1:0];
          mem_addr_d = req_addr[ADDR_W-1:2];
          if (req_err_c) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d     = S_WRITE;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        if (we_q) begin
          state_d     = S_WRITE;
          mem_wdata_d = merged_c;
        end else begin
          state_d     = S_RESP;
          rsp_rdata_d = load_ext_c;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Moore strobes follow the state being entered
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    mem_en_d    = (state_d == S_READ) || (state_d == S_WRITE);
    mem_we_d    = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Self-checking bench for mem_lane_ctrl: directed plan cases, then random
// accesses checked against a byte-array model of the memory.
module tb_mem_lane_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WA_W   = ADDR_W - 2;
  localparam int unsigned NWORDS = 1 << WA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [WA_W-1:0]   mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [31:0] mem [NWORDS];
  logic [7:0]  ref_b [NWORDS*4];

  mem_lane_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory; not affected by controller reset
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Little-endian gather of n bytes, then two's-complement extension
  function automatic logic [31:0] ref_load(input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic uns);
    longint v;
    int n;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_b[int'(a) + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_b[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  // One request; every cycle until the response is observed on the falling edge
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        output logic [31:0] obs_rd, output logic [31:0] obs_wd);
    bit          e_err;
    int          e_lat, e_en, e_wc, lat, en_cnt, wr_cyc, bad_wd, waitc;
    logic [31:0] e_rd, e_wd, rd, wdat;
    logic        er;
    logic [WA_W-1:0] e_addr, first_addr;

    e_err  = ref_err(sz, a);
    e_lat  = e_err ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
    e_en   = e_err ? 0 : ((we && sz != 2'd2) ? 2 : 1);
    e_wc   = (e_err || !we) ? 0 : (sz == 2'd2 ? 1 : 3);
    e_rd   = (e_err || we) ? 32'h0 : ref_load(a, sz, uns);
    e_addr = e_err ? '0 : WA_W'(int'(a) >> 2);
    if (we && !e_err) ref_store(a, sz, wd);
    e_wd   = (we && !e_err) ? ref_word(int'(a) >> 2) : 32'h0;

    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_before_req", 32'(req_ready), 32'h1);

    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    lat = 0; en_cnt = 0; wr_cyc = 0; bad_wd = 0;
    rd = 32'h0; er = 1'b0; wdat = 32'h0; first_addr = '0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_en) begin
        if (en_cnt == 0) first_addr = mem_addr;
        en_cnt++;
        if (mem_we) begin
          wr_cyc = c;
          wdat   = mem_wdata;
        end
      end
      if (!mem_we && mem_wdata != 32'h0) bad_wd++;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
      end
    end
    chk("latency",     32'(lat),        32'(e_lat));
    chk("rsp_err",     32'(er),         32'(e_err));
    chk("rsp_rdata",   rd,              e_rd);
    chk("mem_en_cnt",  32'(en_cnt),     32'(e_en));
    chk("write_cycle", 32'(wr_cyc),     32'(e_wc));
    chk("mem_wdata",   wdat,            e_wd);
    chk("mem_addr",    32'(first_addr), 32'(e_addr));
    chk("wdata_idle0", 32'(bad_wd),     32'h0);
    @(negedge clk);
    chk("rsp_pulse",   32'(rsp_valid),  32'h0);
    obs_rd = rd;
    obs_wd = wdat;
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic        r_we, r_uns;
    logic [1:0]  r_sz;
    int          pick;

    for (int i = 0; i < int'(NWORDS) * 4; i++) ref_b[i] = 8'h00;

    // Reset held for two edges with a request pending
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mem_en",    32'(mem_en),    32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    chk("post_rst_outs",
        {rsp_valid, rsp_err, mem_en, mem_we, 28'h0} | rsp_rdata | 32'(mem_addr) | mem_wdata,
        32'h0);

    // Fill words 0..15 with random data through word stores
    for (int w = 0; w < 16; w++) do_req(1'b1, 2'd2, 1'b0, ADDR_W'(4 * w), $urandom, rd, wd);

    do_req(1'b1, 2'd2, 1'b0, 12'h00C, 32'h80FF_7F01, rd, wd);
    do_req(1'b0, 2'd0, 1'b0, 12'h00E, 32'h0, rd, wd);
    chk("plan_lb",  rd, 32'hFFFF_FFFF);
    do_req(1'b0, 2'd0, 1'b1, 12'h00F, 32'h0, rd, wd);
    chk("plan_lbu", rd, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b0, 12'h00C, 32'h0, rd, wd);
    chk("plan_lh",  rd, 32'h0000_7F01);
    do_req(1'b0, 2'd1, 1'b1, 12'h00E, 32'h0, rd, wd);
    chk("plan_lhu", rd, 32'h0000_80FF);

    do_req(1'b1, 2'd2, 1'b0, 12'h014, 32'h1122_3344, rd, wd);
    do_req(1'b1, 2'd0, 1'b0, 12'h015, 32'h0000_00AB, rd, wd);
    chk("plan_sb_wdata", wd, 32'h1122_AB44);
    do_req(1'b1, 2'd1, 1'b0, 12'h016, 32'h0000_BEEF, rd, wd);
    chk("plan_sh_wdata", wd, 32'hBEEF_AB44);
    do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'hDEAD_BEEF, rd, wd);
    chk("plan_sw_wdata", wd, 32'hDEAD_BEEF);

    do_req(1'b0, 2'd1, 1'b0, 12'h001, 32'h0, rd, wd);
    do_req(1'b1, 2'd2, 1'b0, 12'h002, 32'h1234_5678, rd, wd);
    do_req(1'b0, 2'd3, 1'b0, 12'h004, 32'h0, rd, wd);

    // Reset during CAPT of a byte store aborts it
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 12'h015; req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_en",    32'(mem_en),    32'h0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("abort_ready",     32'(req_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_kept", mem[5], ref_word(5));
    do_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0, rd, wd);
    chk("abort_readback", rd, 32'hBEEF_AB44);

    // Random mix over words 0..15
    for (int t = 0; t < 80; t++) begin
      pick  = $urandom_range(0, 7);
      r_sz  = (pick < 3) ? 2'd0 : (pick < 5) ? 2'd1 : (pick < 7) ? 2'd2 : 2'd3;
      r_we  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      do_req(r_we, r_sz, r_uns, ADDR_W'($urandom_range(0, 63)), $urandom, rd, wd);
    end

    for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(w));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
